// File: rtl/coffee_brewer_if.sv
// Order/drink handshake bundle for the coffee brewer.
// The brewer connects through the slave modport; the order source and drink consumer use master.
interface coffee_brewer_if;
  logic       order_valid;
  logic       order_ready;
  logic       order_size;
  logic       order_milk;
  logic       order_foam;
  logic       drink_valid;
  logic       drink_ready;
  logic [1:0] drink_type;
  logic       reject;
  logic       busy;

  modport master (
    output order_valid, order_size, order_milk, order_foam, drink_ready,
    input  order_ready, drink_valid, drink_type, reject, busy
  );

  modport slave (
    input  order_valid, order_size, order_milk, order_foam, drink_ready,
    output order_ready, drink_valid, drink_type, reject, busy
  );
endinterface

// File: rtl/coffee_brewer.sv
// Coffee brewer: order FIFO feeding a BREW/MILK/FOAM/DONE stage machine.
// Optional feature macro COFFEE_BREWER_STATS_EN adds a 16-bit served_count port
// that counts drink handshakes.
module coffee_brewer #(
  parameter int BREW_CYCLES = 4,
  parameter int MILK_CYCLES = 3,
  parameter int FOAM_CYCLES = 2,
  parameter int QUEUE_DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
`ifdef COFFEE_BREWER_STATS_EN
  output logic [15:0] served_count,
`endif
  coffee_brewer_if.slave bus
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_BREW = 3'd1;
  localparam logic [2:0] S_MILK = 3'd2;
  localparam logic [2:0] S_FOAM = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [1:0] T_NONE  = 2'd0;
  localparam logic [1:0] T_ESP   = 2'd1;
  localparam logic [1:0] T_LATTE = 2'd2;
  localparam logic [1:0] T_CAPP  = 2'd3;

  localparam int PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(QUEUE_DEPTH);

  // Stage counters run 0..len-1, so the terminal value is len-1.
  localparam logic [15:0] BREW_LAST_S = 16'(BREW_CYCLES - 1);
  localparam logic [15:0] BREW_LAST_L = 16'(2 * BREW_CYCLES - 1);
  localparam logic [15:0] MILK_LAST   = 16'(MILK_CYCLES - 1);
  localparam logic [15:0] FOAM_LAST   = 16'(FOAM_CYCLES - 1);

  logic [2:0]       r_state;
  logic [15:0]      r_stageCnt;
  logic [1:0]       r_curType;
  logic             r_curSize;
  logic [2:0]       r_mem [QUEUE_DEPTH];
  logic [PTR_W-1:0] r_wrPtr;
  logic [PTR_W-1:0] r_rdPtr;
  logic [CNT_W-1:0] r_count;
  logic             r_reject;

  logic        w_full;
  logic        w_empty;
  logic        w_accept;
  logic        w_codeValid;
  logic [1:0]  w_orderType;
  logic        w_push;
  logic        w_pop;
  logic        w_drinkDone;
  logic [15:0] w_stageLast;
  logic        w_stageEnd;

  assign w_full      = (r_count == FULL_COUNT);
  assign w_empty     = (r_count == '0);
  assign w_accept    = bus.order_valid && bus.order_ready;
  assign w_push      = w_accept && w_codeValid;
  assign w_pop       = (r_state == S_IDLE) && !w_empty;
  assign w_drinkDone = (r_state == S_DONE) && bus.drink_ready;
  assign w_stageEnd  = (r_stageCnt == w_stageLast);

  // Decode {size,milk,foam}; milk is only offered on LARGE and foam only with milk.
  always_comb begin
    w_orderType = T_NONE;
    w_codeValid = 1'b0;
    case ({bus.order_size, bus.order_milk, bus.order_foam})
      3'b000, 3'b100: begin
        w_orderType = T_ESP;
        w_codeValid = 1'b1;
      end
      3'b110: begin
        w_orderType = T_LATTE;
        w_codeValid = 1'b1;
      end
      3'b111: begin
        w_orderType = T_CAPP;
        w_codeValid = 1'b1;
      end
      default: begin
        w_orderType = T_NONE;
        w_codeValid = 1'b0;
      end
    endcase
  end

  // Pick the terminal count for whichever stage is currently running.
  always_comb begin
    w_stageLast = 16'd0;
    case (r_state)
      S_BREW:  w_stageLast = r_curSize ? BREW_LAST_L : BREW_LAST_S;
      S_MILK:  w_stageLast = MILK_LAST;
      S_FOAM:  w_stageLast = FOAM_LAST;
      default: w_stageLast = 16'd0;
    endcase
  end

  // FIFO storage holds {type,size}; contents need no reset because occupancy gates every read.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wrPtr] <= {w_orderType, bus.order_size};
    end
  end

  // FIFO pointers and occupancy; a coinciding push and pop leave the count unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wrPtr <= r_wrPtr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Drink stage machine: IDLE pops an order, then each stage runs for its length.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_stageCnt <= 16'd0;
      r_curType  <= T_NONE;
      r_curSize  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!w_empty) begin
            {r_curType, r_curSize} <= r_mem[r_rdPtr];
            r_stageCnt <= 16'd0;
            r_state    <= S_BREW;
          end
        end
        S_BREW: begin
          if (w_stageEnd) begin
            r_stageCnt <= 16'd0;
            r_state    <= (r_curType == T_ESP) ? S_DONE : S_MILK;
          end else begin
            r_stageCnt <= r_stageCnt + 16'd1;
          end
        end
        S_MILK: begin
          if (w_stageEnd) begin
            r_stageCnt <= 16'd0;
            r_state    <= (r_curType == T_CAPP) ? S_FOAM : S_DONE;
          end else begin
            r_stageCnt <= r_stageCnt + 16'd1;
          end
        end
        S_FOAM: begin
          if (w_stageEnd) begin
            r_stageCnt <= 16'd0;
            r_state    <= S_DONE;
          end else begin
            r_stageCnt <= r_stageCnt + 16'd1;
          end
        end
        S_DONE: begin
          if (bus.drink_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_stageCnt <= 16'd0;
        end
      endcase
    end
  end

  // Invalid orders are swallowed and flagged for exactly the following cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_reject <= 1'b0;
    end else begin
      r_reject <= w_accept && !w_codeValid;
    end
  end

`ifdef COFFEE_BREWER_STATS_EN
  // Count completed drink handshakes; the counter wraps naturally at 16 bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      served_count <= 16'd0;
    end else if (w_drinkDone) begin
      served_count <= served_count + 16'd1;
    end
  end
`endif

  // Outputs are forced to idle values for the whole time reset is held, not just after its first edge.
  assign bus.order_ready = !rst && !w_full;
  assign bus.drink_valid = !rst && (r_state == S_DONE);
  assign bus.drink_type  = bus.drink_valid ? r_curType : T_NONE;
  assign bus.reject      = !rst && r_reject;
  assign bus.busy        = !rst && ((r_state != S_IDLE) || !w_empty);

endmodule

// File: tb/tb_coffee_brewer.sv
// Self-checking bench for coffee_brewer using directed orders and hand-computed timing.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_coffee_brewer;

  logic clk = 1'b0;
  logic rst;

  int checkCount = 0;
  int passCount  = 0;

  coffee_brewer_if bus ();

`ifdef COFFEE_BREWER_STATS_EN
  logic [15:0] servedCount;
  coffee_brewer dut (
    .clk          (clk),
    .rst          (rst),
    .served_count (servedCount),
    .bus          (bus)
  );
`else
  coffee_brewer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );
`endif

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  task automatic test_reset();
    rst = 1'b1;
    bus.order_valid = 1'b0;
    bus.order_size  = 1'b0;
    bus.order_milk  = 1'b0;
    bus.order_foam  = 1'b0;
    bus.drink_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkCount++;
    if (bus.order_ready !== 1'b0) $display("[TB] FAIL reset_order_ready: got %b, expected 0", bus.order_ready);
    else passCount++;
    checkCount++;
    if (bus.drink_valid !== 1'b0) $display("[TB] FAIL reset_drink_valid: got %b, expected 0", bus.drink_valid);
    else passCount++;
    checkCount++;
    if (bus.drink_type !== 2'd0) $display("[TB] FAIL reset_drink_type: got %0d, expected 0", bus.drink_type);
    else passCount++;
    checkCount++;
    if (bus.reject !== 1'b0) $display("[TB] FAIL reset_reject: got %b, expected 0", bus.reject);
    else passCount++;
    checkCount++;
    if (bus.busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b, expected 0", bus.busy);
    else passCount++;
    rst = 1'b0;
    @(negedge clk);
    checkCount++;
    if (bus.order_ready !== 1'b1) $display("[TB] FAIL post_reset_ready: got %b, expected 1", bus.order_ready);
    else passCount++;
    checkCount++;
    if (bus.busy !== 1'b0) $display("[TB] FAIL post_reset_busy: got %b, expected 0", bus.busy);
    else passCount++;
  endtask

  // One order into an idle brewer; measures cycles from the accept cycle to drink_valid.
  task automatic test_latency(input logic [2:0] code, input logic [1:0] expType, input int expLat);
    int k;
    int firstK;
    logic [1:0] heldType;
    firstK = -1;
    checkCount++;
    if (bus.order_ready !== 1'b1) $display("[TB] FAIL lat_ready_%b: got %b, expected 1", code, bus.order_ready);
    else passCount++;
    {bus.order_size, bus.order_milk, bus.order_foam} = code;
    bus.order_valid = 1'b1;
    @(negedge clk);
    bus.order_valid = 1'b0;
    k = 1;
    checkCount++;
    if (bus.busy !== 1'b1) $display("[TB] FAIL lat_busy_%b: got %b, expected 1", code, bus.busy);
    else passCount++;
    while (k <= 40 && firstK < 0) begin
      if (bus.drink_valid === 1'b1) begin
        firstK = k;
      end else begin
        @(negedge clk);
        k++;
      end
    end
    checkCount++;
    if (firstK != expLat) $display("[TB] FAIL latency_%b: got %0d, expected %0d", code, firstK, expLat);
    else passCount++;
    checkCount++;
    if (bus.drink_type !== expType) $display("[TB] FAIL type_%b: got %0d, expected %0d", code, bus.drink_type, expType);
    else passCount++;
    heldType = bus.drink_type;
    @(negedge clk);
    @(negedge clk);
    checkCount++;
    if (bus.drink_valid !== 1'b1 || bus.drink_type !== expType)
      $display("[TB] FAIL hold_%b: got valid=%b type=%0d (was %0d), expected valid=1 type=%0d",
               code, bus.drink_valid, bus.drink_type, heldType, expType);
    else passCount++;
    bus.drink_ready = 1'b1;
    @(negedge clk);
    bus.drink_ready = 1'b0;
    checkCount++;
    if ({bus.drink_valid, bus.drink_type, bus.busy} !== 4'b0000)
      $display("[TB] FAIL after_take_%b: got valid=%b type=%0d busy=%b, expected 0/0/0",
               code, bus.drink_valid, bus.drink_type, bus.busy);
    else passCount++;
  endtask

  // An invalid order is consumed, pulses reject once and never reaches the queue.
  task automatic test_reject(input logic [2:0] code);
    bit sawDrink;
    checkCount++;
    if (bus.order_ready !== 1'b1) $display("[TB] FAIL rej_ready_%b: got %b, expected 1", code, bus.order_ready);
    else passCount++;
    {bus.order_size, bus.order_milk, bus.order_foam} = code;
    bus.order_valid = 1'b1;
    @(negedge clk);
    bus.order_valid = 1'b0;
    checkCount++;
    if (bus.reject !== 1'b1) $display("[TB] FAIL reject_pulse_%b: got %b, expected 1", code, bus.reject);
    else passCount++;
    checkCount++;
    if (bus.busy !== 1'b0) $display("[TB] FAIL reject_busy_%b: got %b, expected 0", code, bus.busy);
    else passCount++;
    @(negedge clk);
    checkCount++;
    if (bus.reject !== 1'b0) $display("[TB] FAIL reject_once_%b: got %b, expected 0", code, bus.reject);
    else passCount++;
    sawDrink = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (bus.drink_valid !== 1'b0 || bus.busy !== 1'b0) sawDrink = 1'b1;
      @(negedge clk);
    end
    checkCount++;
    if (sawDrink) $display("[TB] FAIL reject_no_drink_%b: got activity=1, expected 0", code);
    else passCount++;
  endtask

  // Fill the queue behind a held drink, then drain and check order and spacing.
  task automatic test_back_to_back();
    logic [2:0] codes [5];
    logic [1:0] expTypes [5];
    int         expGaps [4];
    int         times [5];
    logic [1:0] types [5];
    int n;
    int k;
    codes[0] = 3'b000; expTypes[0] = 2'd1;
    codes[1] = 3'b110; expTypes[1] = 2'd2;
    codes[2] = 3'b111; expTypes[2] = 2'd3;
    codes[3] = 3'b100; expTypes[3] = 2'd1;
    codes[4] = 3'b000; expTypes[4] = 2'd1;
    expGaps[0] = 13; expGaps[1] = 15; expGaps[2] = 10; expGaps[3] = 6;
    for (int i = 0; i < 5; i++) begin
      checkCount++;
      if (bus.order_ready !== 1'b1) $display("[TB] FAIL b2b_ready_%0d: got %b, expected 1", i, bus.order_ready);
      else passCount++;
      {bus.order_size, bus.order_milk, bus.order_foam} = codes[i];
      bus.order_valid = 1'b1;
      @(negedge clk);
    end
    bus.order_valid = 1'b0;
    checkCount++;
    if (bus.order_ready !== 1'b0) $display("[TB] FAIL b2b_full: got %b, expected 0", bus.order_ready);
    else passCount++;
    k = 0;
    while (k < 20 && bus.drink_valid !== 1'b1) begin
      @(negedge clk);
      k++;
    end
    repeat (3) @(negedge clk);
    checkCount++;
    if ({bus.drink_valid, bus.drink_type, bus.order_ready} !== 4'b1010)
      $display("[TB] FAIL b2b_held: got valid=%b type=%0d ready=%b, expected 1/1/0",
               bus.drink_valid, bus.drink_type, bus.order_ready);
    else passCount++;
    n = 0;
    k = 0;
    bus.drink_ready = 1'b1;
    while (n < 5 && k < 200) begin
      if (bus.drink_valid === 1'b1) begin
        times[n] = k;
        types[n] = bus.drink_type;
        n++;
      end
      @(negedge clk);
      k++;
    end
    bus.drink_ready = 1'b0;
    checkCount++;
    if (n != 5) $display("[TB] FAIL b2b_count: got %0d, expected 5", n);
    else passCount++;
    for (int i = 0; i < n; i++) begin
      checkCount++;
      if (types[i] !== expTypes[i]) $display("[TB] FAIL b2b_type_%0d: got %0d, expected %0d", i, types[i], expTypes[i]);
      else passCount++;
    end
    for (int i = 0; i + 1 < n; i++) begin
      checkCount++;
      if (times[i+1] - times[i] != expGaps[i])
        $display("[TB] FAIL b2b_gap_%0d: got %0d, expected %0d", i, times[i+1] - times[i], expGaps[i]);
      else passCount++;
    end
    checkCount++;
    if (bus.busy !== 1'b0) $display("[TB] FAIL b2b_idle_busy: got %b, expected 0", bus.busy);
    else passCount++;
  endtask

  // Reset during the milk stage of a large latte with two orders waiting behind it.
  task automatic test_reset_mid();
    bit sawDrink;
    {bus.order_size, bus.order_milk, bus.order_foam} = 3'b110;
    bus.order_valid = 1'b1;
    @(negedge clk);
    {bus.order_size, bus.order_milk, bus.order_foam} = 3'b000;
    @(negedge clk);
    @(negedge clk);
    bus.order_valid = 1'b0;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    #1;
    checkCount++;
    if ({bus.order_ready, bus.drink_valid, bus.drink_type, bus.reject, bus.busy} !== 6'b0)
      $display("[TB] FAIL mid_rst_held: got %b, expected 000000",
               {bus.order_ready, bus.drink_valid, bus.drink_type, bus.reject, bus.busy});
    else passCount++;
    @(negedge clk);
    checkCount++;
    if ({bus.order_ready, bus.drink_valid, bus.drink_type, bus.reject, bus.busy} !== 6'b0)
      $display("[TB] FAIL mid_rst_next: got %b, expected 000000",
               {bus.order_ready, bus.drink_valid, bus.drink_type, bus.reject, bus.busy});
    else passCount++;
    rst = 1'b0;
    @(negedge clk);
    checkCount++;
    if ({bus.order_ready, bus.busy} !== 2'b10)
      $display("[TB] FAIL mid_rst_release: got ready=%b busy=%b, expected 1/0", bus.order_ready, bus.busy);
    else passCount++;
    bus.drink_ready = 1'b1;
    sawDrink = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (bus.drink_valid !== 1'b0 || bus.busy !== 1'b0) sawDrink = 1'b1;
      @(negedge clk);
    end
    bus.drink_ready = 1'b0;
    checkCount++;
    if (sawDrink) $display("[TB] FAIL mid_rst_no_drink: got activity=1, expected 0");
    else passCount++;
  endtask

`ifdef COFFEE_BREWER_STATS_EN
  // Served counter advances only on a drink handshake, never while a drink waits.
  task automatic test_stats();
    int k;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkCount++;
    if (servedCount !== 16'd0) $display("[TB] FAIL stats_reset: got %0d, expected 0", servedCount);
    else passCount++;
    for (int i = 0; i < 3; i++) begin
      {bus.order_size, bus.order_milk, bus.order_foam} = 3'b000;
      bus.order_valid = 1'b1;
      @(negedge clk);
      bus.order_valid = 1'b0;
      k = 0;
      while (k < 20 && bus.drink_valid !== 1'b1) begin
        @(negedge clk);
        k++;
      end
      repeat (3) @(negedge clk);
      checkCount++;
      if (servedCount !== 16'(i)) $display("[TB] FAIL stats_hold_%0d: got %0d, expected %0d", i, servedCount, i);
      else passCount++;
      bus.drink_ready = 1'b1;
      @(negedge clk);
      bus.drink_ready = 1'b0;
    end
    checkCount++;
    if (servedCount !== 16'd3) $display("[TB] FAIL stats_three: got %0d, expected 3", servedCount);
    else passCount++;
  endtask
`endif

  initial begin
    test_reset();
    test_latency(3'b000, 2'd1, 6);
    test_latency(3'b110, 2'd2, 13);
    test_latency(3'b111, 2'd3, 15);
    test_latency(3'b100, 2'd1, 10);
    test_reject(3'b001);
    test_reject(3'b011);
    test_reject(3'b101);
    test_back_to_back();
    test_reset_mid();
`ifdef COFFEE_BREWER_STATS_EN
    test_stats();
`endif
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/coffee_brewer.md
COFFEE_BREWER -- requirements
Module: coffee_brewer

Interface
REQ-001 Parameter BREW_CYCLES, default 4: base espresso stage length in cycles (>=1).
REQ-002 Parameter MILK_CYCLES, default 3: milk stage length in cycles (>=1).
REQ-003 Parameter FOAM_CYCLES, default 2: foam stage length in cycles (>=1).
REQ-004 Parameter QUEUE_DEPTH, default 4: order FIFO entries (power of two, >=2).
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst  input  1  reset, synchronous and active-high.
REQ-007 order_valid  input  1  an order is presented.
REQ-008 order_ready  output  1  FIFO can accept an order.
REQ-009 order_size  input  1  0=SMALL, 1=LARGE.
REQ-010 order_milk / order_foam  input  1 each  order options.
REQ-011 drink_valid  output  1  finished drink is presented.
REQ-012 drink_ready  input  1  consumer takes the drink.
REQ-013 drink_type  output  2  0=NONE, 1=ESPRESSO, 2=LATTE, 3=CAPPUCCINO.
REQ-014 reject  output  1  one-cycle pulse for an invalid order.
REQ-015 busy  output  1  high when the FSM is not in IDLE or the FIFO is non-empty.

Function
REQ-016 Decode {size,milk,foam}: 000/100 -> ESPRESSO; 110 -> LATTE; 111 -> CAPPUCCINO; x01, 010, 011 -> invalid.
REQ-017 An order handshake (order_valid && order_ready) with a valid code writes {type,size} into the FIFO.
REQ-018 A handshake with an invalid code is consumed and not queued; reject is high for exactly the following cycle.
REQ-019 order_ready = !full, depending only on FIFO occupancy; no same-cycle bypass when a pop coincides.
REQ-020 Simultaneous push and pop in one cycle: both take effect and occupancy is unchanged.
REQ-021 FSM states are IDLE, BREW, MILK, FOAM, DONE.
REQ-022 IDLE with a non-empty FIFO pops the head and goes to BREW; IDLE with an empty FIFO stays in IDLE.
REQ-023 BREW lasts BREW_CYCLES (2*BREW_CYCLES if LARGE); it then goes to MILK for LATTE/CAPPUCCINO, or to DONE for ESPRESSO.
REQ-024 MILK lasts MILK_CYCLES; it then goes to FOAM for CAPPUCCINO, otherwise to DONE.
REQ-025 FOAM lasts FOAM_CYCLES, then goes to DONE.
REQ-026 In DONE, drink_valid=1 and drink_type holds the popped type, stable until drink_ready; the handshake returns the FSM to IDLE.
REQ-027 Outside DONE, drink_valid=0 and drink_type=NONE.
REQ-028 Latency from the accept cycle (empty FIFO, IDLE FSM) to the first drink_valid cycle = 2 + brew + milk + foam stage cycles.
REQ-029 Back-to-back drinks spend one IDLE cycle between DONE and the next BREW.
REQ-030 drink_ready while not in DONE is ignored.

Reset
REQ-031 While rst=1: FIFO emptied, FSM=IDLE, stage counter=0, order_ready=0, drink_valid=0, drink_type=NONE, reject=0, busy=0.
REQ-032 First cycle after rst deasserts: order_ready=1.
REQ-033 Reset mid-brew abandons the drink in progress and all queued orders; no drink_valid is produced for them.

Configuration
REQ-034 With `COFFEE_BREWER_STATS_EN defined, add port served_count (output, 16 bits) that counts drink handshakes, wraps 0xFFFF->0, and resets to 0.
REQ-035 Without `COFFEE_BREWER_STATS_EN, the port and counter are absent and all other behaviour is identical.

Verification
REQ-036 Defaults; small espresso (000) accepted in cycle 0 -> drink_valid=1, drink_type=1 from cycle 6.
REQ-037 Large latte (110) accepted in cycle 0 -> drink_valid from cycle 13, drink_type=2; large cappuccino (111) -> cycle 15, type 3.
REQ-038 Order 001, then 011 -> reject pulses once per order, FIFO stays empty, busy stays 0, no drink produced.
REQ-039 drink_ready=0, push 5 valid orders -> order_ready=0 after FIFO reaches 4 entries (first order already in the FSM); release drink_ready -> 5 drinks delivered in order.
REQ-040 Assert rst during MILK of a latte with 2 orders queued -> next cycle all outputs at reset values; no drinks afterwards.
REQ-041 With COFFEE_BREWER_STATS_EN defined, serve 3 drinks -> served_count=3; with drink_valid held and drink_ready low, served_count does not advance.
